// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  localparam int DEF_NREGS = 32;
  localparam int DEF_XLEN  = 64;
  localparam int DEF_AW    = clog2(DEF_NREGS);

  typedef logic [DEF_AW-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_ADDR = '0;

  typedef struct packed {
    logic                en;
    reg_addr_t           addr;
    logic [DEF_XLEN-1:0] data;
  } wr_port_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write bits: flush > issue set > writeback clear > hold.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS    = 32,
  parameter int NWR      = 2,
  parameter bit ZERO_REG = 1,
  localparam int AW      = clog2(NREGS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    issue_en,
  input  logic [AW-1:0]           issue_addr,
  input  logic                    flush,
  input  logic [NWR-1:0]          wr_en,
  input  logic [NWR-1:0][AW-1:0]  wr_addr,
  output logic [NREGS-1:0]        busy_vec,
  output logic [AW:0]             busy_cnt
);

  logic [NREGS-1:0] busy_d, busy_q, wr_hit;
  logic [AW:0]      cnt_d, cnt_q;

  always_comb begin
    wr_hit = '0;
    for (int p = 0; p < NWR; p++)
      if (wr_en[p]) wr_hit[wr_addr[p]] = 1'b1;

    busy_d = busy_q;
    for (int r = 0; r < NREGS; r++) begin
      if (flush)                                   busy_d[r] = 1'b0;
      else if (issue_en && issue_addr == AW'(r))   busy_d[r] = 1'b1;
      else if (wr_hit[r])                          busy_d[r] = 1'b0;
    end
    if (ZERO_REG) busy_d[0] = 1'b0;

    // Count follows the next-state vector so both update on the same edge.
    cnt_d = '0;
    for (int r = 0; r < NREGS; r++)
      cnt_d = cnt_d + {{AW{1'b0}}, busy_d[r]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_vec = busy_q;
  assign busy_cnt = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-through bypass and busy scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter bit BYPASS   = 1,
  parameter bit ZERO_REG = 1,
  localparam int AW      = clog2(NREGS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NRD-1:0][AW-1:0]   rd_addr,
  output logic [NRD-1:0][XLEN-1:0] rd_data,
  output logic [NRD-1:0]           rd_busy,
  input  logic [NWR-1:0]           wr_en,
  input  logic [NWR-1:0][AW-1:0]   wr_addr,
  input  logic [NWR-1:0][XLEN-1:0] wr_data,
  input  logic                     issue_en,
  input  logic [AW-1:0]            issue_addr,
  input  logic                     flush,
  output logic [NREGS-1:0]         busy_vec,
  output logic [AW:0]              busy_cnt,
  output logic                     wr_conflict
);

  logic [NREGS-1:0][XLEN-1:0] mem_d, mem_q;
  logic                       wr_conflict_d, wr_conflict_q;
  logic [NWR-1:0]             wr_live;

  always_comb begin
    for (int p = 0; p < NWR; p++)
      wr_live[p] = wr_en[p] && !(ZERO_REG && wr_addr[p] == AW'(ZERO_ADDR));

    // Ascending port order makes the highest-index port win a collision.
    mem_d = mem_q;
    for (int p = 0; p < NWR; p++)
      if (wr_live[p]) mem_d[wr_addr[p]] = wr_data[p];

    wr_conflict_d = 1'b0;
    for (int p = 0; p < NWR; p++)
      for (int q = p + 1; q < NWR; q++)
        if (wr_live[p] && wr_live[q] && wr_addr[p] == wr_addr[q])
          wr_conflict_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q         <= '0;
      wr_conflict_q <= 1'b0;
    end else begin
      mem_q         <= mem_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

  assign wr_conflict = wr_conflict_q;

  regfile_scoreboard #(
    .NREGS    (NREGS),
    .NWR      (NWR),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk        (clk),
    .reset      (reset),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .flush      (flush),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .busy_vec   (busy_vec),
    .busy_cnt   (busy_cnt)
  );

  // Forwarded data is already in flight, so a bypass hit is never busy.
  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      rd_data[i] = mem_q[rd_addr[i]];
      rd_busy[i] = busy_vec[rd_addr[i]];
      if (BYPASS)
        for (int p = 0; p < NWR; p++)
          if (wr_en[p] && wr_addr[p] == rd_addr[i]) begin
            rd_data[i] = wr_data[p];
            rd_busy[i] = 1'b0;
          end
      if (ZERO_REG && rd_addr[i] == AW'(ZERO_ADDR)) begin
        rd_data[i] = '0;
        rd_busy[i] = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Table-driven check of regfile_mp (default parameters) plus async-reset sequences.
module tb_regfile_mp;

  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  logic                 clk;
  logic                 reset;
  logic [1:0][AW-1:0]   rd_addr;
  logic [1:0][XLEN-1:0] rd_data;
  logic [1:0]           rd_busy;
  logic [1:0]           wr_en;
  logic [1:0][AW-1:0]   wr_addr;
  logic [1:0][XLEN-1:0] wr_data;
  logic                 issue_en;
  logic [AW-1:0]        issue_addr;
  logic                 flush;
  logic [NREGS-1:0]     busy_vec;
  logic [AW:0]          busy_cnt;
  logic                 wr_conflict;

  regfile_mp dut (
    .clk         (clk),
    .reset       (reset),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_busy     (rd_busy),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .issue_en    (issue_en),
    .issue_addr  (issue_addr),
    .flush       (flush),
    .busy_vec    (busy_vec),
    .busy_cnt    (busy_cnt),
    .wr_conflict (wr_conflict)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [XLEN-1:0]  rd0;
    logic [XLEN-1:0]  rd1;
    logic [1:0]       busy;
    logic [NREGS-1:0] bvec;
    logic [AW:0]      cnt;
    logic             conf;
  } exp_t;

  typedef struct {
    logic [1:0]      we;
    logic [AW-1:0]   wa0;
    logic [XLEN-1:0] wd0;
    logic [AW-1:0]   wa1;
    logic [XLEN-1:0] wd1;
    logic            ie;
    logic [AW-1:0]   ia;
    logic            fl;
    logic [AW-1:0]   ra0;
    logic [AW-1:0]   ra1;
    exp_t            e;
  } vec_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic add(input logic [1:0] we, input int wa0, input logic [XLEN-1:0] wd0,
                     input int wa1, input logic [XLEN-1:0] wd1, input logic ie, input int ia,
                     input logic fl, input int ra0, input int ra1,
                     input logic [XLEN-1:0] erd0, input logic [XLEN-1:0] erd1,
                     input logic [1:0] ebusy, input logic [NREGS-1:0] ebvec,
                     input int ecnt, input logic econf);
    vec_t v;
    v.we = we;  v.wa0 = AW'(wa0); v.wd0 = wd0; v.wa1 = AW'(wa1); v.wd1 = wd1;
    v.ie = ie;  v.ia = AW'(ia);   v.fl = fl;   v.ra0 = AW'(ra0); v.ra1 = AW'(ra1);
    v.e.rd0 = erd0; v.e.rd1 = erd1; v.e.busy = ebusy; v.e.bvec = ebvec;
    v.e.cnt = (AW+1)'(ecnt); v.e.conf = econf;
    vecs.push_back(v);
  endtask

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0;
    issue_en = 1'b0; issue_addr = '0; flush = 1'b0;
  endtask

  initial begin
    exp_t e;
    vec_t v;
    reset = 1'b1;
    rd_addr = '0;
    idle();

    // Each row: one cycle; expectations are outputs just before that cycle's edge.
    //   we     wa0 wd0            wa1 wd1    ie ia  fl ra0 ra1  rd0            rd1            busy  bvec   cnt conf
    add(2'b00, 0, 0,             0, 0,     0, 0,  0, 5,  0,   0,             0,             2'b00, 32'h0,   0, 0);
    add(2'b01, 5, 64'hDEADBEEF,  0, 0,     0, 0,  0, 5,  0,   64'hDEADBEEF,  0,             2'b00, 32'h0,   0, 0);
    add(2'b00, 0, 0,             0, 0,     0, 0,  0, 5,  1,   64'hDEADBEEF,  0,             2'b00, 32'h0,   0, 0);
    add(2'b01, 0, 64'h1234,      0, 0,     0, 0,  0, 0,  5,   0,             64'hDEADBEEF,  2'b00, 32'h0,   0, 0);
    add(2'b00, 0, 0,             0, 0,     0, 0,  0, 0,  0,   0,             0,             2'b00, 32'h0,   0, 0);
    add(2'b11, 7, 64'h11,        7, 64'h22,0, 0,  0, 7,  5,   64'h22,        64'hDEADBEEF,  2'b00, 32'h0,   0, 0);
    add(2'b00, 0, 0,             0, 0,     0, 0,  0, 7,  0,   64'h22,        0,             2'b00, 32'h0,   0, 1);
    add(2'b00, 0, 0,             0, 0,     0, 0,  0, 7,  0,   64'h22,        0,             2'b00, 32'h0,   0, 0);
    add(2'b00, 0, 0,             0, 0,     1, 3,  0, 3,  0,   0,             0,             2'b00, 32'h0,   0, 0);
    add(2'b00, 0, 0,             0, 0,     0, 0,  0, 3,  5,   0,             64'hDEADBEEF,  2'b01, 32'h8,   1, 0);
    add(2'b10, 0, 0,             3, 64'h33,0, 0,  0, 3,  0,   64'h33,        0,             2'b00, 32'h8,   1, 0);
    add(2'b00, 0, 0,             0, 0,     0, 0,  0, 3,  0,   64'h33,        0,             2'b00, 32'h0,   0, 0);
    add(2'b01, 9, 64'h99,        0, 0,     1, 9,  0, 9,  0,   64'h99,        0,             2'b00, 32'h0,   0, 0);
    add(2'b00, 0, 0,             0, 0,     0, 0,  0, 9,  0,   64'h99,        0,             2'b01, 32'h200, 1, 0);
    add(2'b00, 0, 0,             0, 0,     1, 10, 1, 9,  10,  64'h99,        0,             2'b01, 32'h200, 1, 0);
    add(2'b00, 0, 0,             0, 0,     0, 0,  0, 9,  10,  64'h99,        0,             2'b00, 32'h0,   0, 0);
    add(2'b00, 0, 0,             0, 0,     1, 0,  0, 0,  0,   0,             0,             2'b00, 32'h0,   0, 0);
    add(2'b00, 0, 0,             0, 0,     0, 0,  0, 0,  0,   0,             0,             2'b00, 32'h0,   0, 0);
    add(2'b00, 0, 0,             0, 0,     1, 1,  0, 1,  0,   0,             0,             2'b00, 32'h0,   0, 0);
    add(2'b00, 0, 0,             0, 0,     1, 2,  0, 1,  0,   0,             0,             2'b01, 32'h2,   1, 0);
    add(2'b00, 0, 0,             0, 0,     1, 1,  0, 2,  0,   0,             0,             2'b01, 32'h6,   2, 0);
    add(2'b00, 0, 0,             0, 0,     0, 0,  0, 1,  2,   0,             0,             2'b11, 32'h6,   2, 0);
    add(2'b11, 0, 64'h5,         0, 64'h6, 0, 0,  0, 0,  1,   0,             0,             2'b10, 32'h6,   2, 0);
    add(2'b00, 0, 0,             0, 0,     0, 0,  0, 0,  0,   0,             0,             2'b00, 32'h6,   2, 0);
    add(2'b11, 1, 64'hA1,        2, 64'hA2,0, 0,  0, 1,  2,   64'hA1,        64'hA2,        2'b00, 32'h6,   2, 0);
    add(2'b00, 0, 0,             0, 0,     0, 0,  0, 1,  2,   64'hA1,        64'hA2,        2'b00, 32'h0,   0, 0);

    // Reset state across a spread of addresses.
    #2;
    chk("rst_busy_vec", 64'(busy_vec), 64'h0);
    chk("rst_busy_cnt", 64'(busy_cnt), 64'h0);
    chk("rst_conflict", 64'(wr_conflict), 64'h0);
    for (int a = 0; a < NREGS; a += 7) begin
      rd_addr[0] = AW'(a); rd_addr[1] = AW'(NREGS - 1 - a);
      #1;
      chk("rst_rd0", rd_data[0], 64'h0);
      chk("rst_rd1", rd_data[1], 64'h0);
      chk("rst_rd_busy", 64'(rd_busy), 64'h0);
    end
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[k]) begin
      @(negedge clk);
      v = vecs[k];
      wr_en = v.we; wr_addr[0] = v.wa0; wr_data[0] = v.wd0;
      wr_addr[1] = v.wa1; wr_data[1] = v.wd1;
      issue_en = v.ie; issue_addr = v.ia; flush = v.fl;
      rd_addr[0] = v.ra0; rd_addr[1] = v.ra1;
      sb_q.push_back(v.e);
      #4;
      e = sb_q.pop_front();
      chk($sformatf("v%0d_rd0", k), rd_data[0], e.rd0);
      chk($sformatf("v%0d_rd1", k), rd_data[1], e.rd1);
      chk($sformatf("v%0d_rd_busy", k), 64'(rd_busy), 64'(e.busy));
      chk($sformatf("v%0d_busy_vec", k), 64'(busy_vec), 64'(e.bvec));
      chk($sformatf("v%0d_busy_cnt", k), 64'(busy_cnt), 64'(e.cnt));
      chk($sformatf("v%0d_conflict", k), 64'(wr_conflict), 64'(e.conf));
    end
    chk("sb_drained", 64'(sb_q.size()), 64'h0);

    // Dirty state, then reset between edges: everything clears without a clock.
    @(negedge clk);
    wr_en = 2'b11; wr_addr[0] = 5'd12; wr_data[0] = 64'h1;
    wr_addr[1] = 5'd12; wr_data[1] = 64'hFF;
    issue_en = 1'b1; issue_addr = 5'd4; flush = 1'b0;
    rd_addr[0] = 5'd12; rd_addr[1] = 5'd4;
    @(posedge clk);
    #1 idle();
    #1;
    chk("pre_rst_x12", rd_data[0], 64'hFF);
    chk("pre_rst_conflict", 64'(wr_conflict), 64'h1);
    chk("pre_rst_cnt", 64'(busy_cnt), 64'h1);
    chk("pre_rst_busy_x4", 64'(rd_busy[1]), 64'h1);
    reset = 1'b1;
    #1;
    chk("async_rst_x12", rd_data[0], 64'h0);
    chk("async_rst_busy_vec", 64'(busy_vec), 64'h0);
    chk("async_rst_cnt", 64'(busy_cnt), 64'h0);
    chk("async_rst_conflict", 64'(wr_conflict), 64'h0);
    chk("async_rst_rd_busy", 64'(rd_busy), 64'h0);

    // A write presented while reset is held must be discarded.
    @(negedge clk);
    wr_en = 2'b01; wr_addr[0] = 5'd13; wr_data[0] = 64'h55;
    @(posedge clk);
    #1 idle();
    @(negedge clk);
    reset = 1'b0;
    rd_addr[0] = 5'd13;
    #1;
    chk("rst_drops_write_x13", rd_data[0], 64'h0);

    // Writes during a flush cycle still land in storage.
    @(negedge clk);
    wr_en = 2'b01; wr_addr[0] = 5'd20; wr_data[0] = 64'hC0FFEE; flush = 1'b1;
    @(negedge clk);
    idle();
    rd_addr[0] = 5'd20;
    #1;
    chk("flush_keeps_write_x20", rd_data[0], 64'hC0FFEE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file with write-through bypass and a per-register pending-write scoreboard. It replaces the fixed 2-read/1-write, 32x64 register file in the decode/writeback boundary of the RISC-V core. Decode reads operands and checks busy bits in one cycle. Issue marks destinations pending, and writeback ports clear them.

## Interface
Parameters:
- XLEN, 64, register width in bits
- NREGS, 32, number of architectural registers (power of two, >=2)
- NRD, 2, number of read ports
- NWR, 2, number of write ports
- BYPASS, 1, when 1, same-cycle write data is forwarded to reads
- ZERO_REG, 1, when 1, register 0 reads as zero, ignores writes, is never busy

Ports (AW = log2(NREGS)):
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- rd_addr  in  NRD x AW  read addresses
- rd_data  out  NRD x XLEN  read data (combinational)
- rd_busy  out  NRD  addressed register has a pending write
- wr_en  in  NWR  write enables
- wr_addr  in  NWR x AW  write addresses
- wr_data  in  NWR x XLEN  write data
- issue_en  in  1  mark issue_addr pending
- issue_addr  in  AW  destination of the issued instruction
- flush  in  1  clear all busy bits (pipeline squash)
- busy_vec  out  NREGS  registered busy bits
- busy_cnt  out  AW+1  registered count of set busy bits
- wr_conflict  out  1  registered; pulses 1 cycle after two enabled write ports target the same non-zero register

## Operation
- Storage: NREGS x XLEN flops. All entries are 0 on reset.
- Write: on posedge clk, for each enabled port, mem[wr_addr] <= wr_data.
  - Port collision on the same address: the highest-index port wins. wr_conflict is set for the next cycle.
  - With ZERO_REG=1, writes to address 0 are dropped and never count as a conflict.
- Read: rd_data[i] = mem[rd_addr[i]].
  - BYPASS=1: if any enabled write port targets rd_addr[i] this cycle, return that port's wr_data (highest index wins).
  - ZERO_REG=1 and rd_addr[i]==0: return 0, overriding bypass.
- Scoreboard, per register r, evaluated on posedge clk with priority top to bottom:
  - reset clears the bit.
  - flush clears the bit.
  - issue_en && issue_addr==r sets the bit.
  - Any enabled write to r clears the bit.
  - Otherwise the bit holds.
  - Issue and writeback to the same r in the same cycle leaves the bit set: the new producer wins.
  - With ZERO_REG=1, bit 0 is constant 0.
- rd_busy[i] = busy[rd_addr[i]].
  - With BYPASS=1, it is forced to 0 when a same-cycle write targets rd_addr[i], because the data is already forwarded.
  - With ZERO_REG=1, it is 0 for address 0.
- busy_cnt tracks the number of set busy bits and is updated in the same clock edge as busy_vec. It is at most NREGS-1 with ZERO_REG=1, else NREGS.
- Issuing to an already-busy register is legal. The bit stays set, and busy_cnt is unchanged.

## Timing
- Read path and rd_busy are fully combinational from rd_addr, wr_*, and state. There is no clock latency.
- Write-to-read latency:
  - BYPASS=1: 0 cycles.
  - BYPASS=0: the value is visible the cycle after the write edge.
- Issue-to-busy: busy_vec/rd_busy reflect an issue 1 cycle after issue_en.
- Writeback-to-not-busy: 0 cycles on rd_busy with BYPASS=1, 1 cycle on busy_vec.
- Reset values: busy_vec=0, busy_cnt=0, wr_conflict=0. rd_data reads 0 for every address and rd_busy=0.
- Reset asserted mid-operation clears storage and scoreboard immediately, independent of clk. Pending write enables in that cycle are discarded.
- flush does not affect storage. Writes in the flush cycle still update mem.

## Structure
- Package regfile_pkg:
  - function clog2-based AW.
  - typedef reg_addr_t (logic [AW-1:0]) for the default NREGS.
  - localparam ZERO_ADDR.
  - typedef wr_port_t struct {en, addr, data}.
- Sub-module regfile_scoreboard: owns busy_vec, busy_cnt, and the set/clear priority logic. Its inputs are issue, flush, and write-port enables/addresses.
- The top level holds storage, the write collision resolution, bypass muxes, and wr_conflict.

## Test plan
- Reset, then write 0xDEAD_BEEF to x5 on port 0 → next cycle rd_addr=5 reads 0xDEAD_BEEF. Same cycle with BYPASS=1 also reads it.
- Write 0x1234 to x0 with a read of x0 the same cycle → rd_data=0, no conflict, busy_vec[0]=0.
- Ports 0 and 1 both write x7, with 0x11 and 0x22 → x7=0x22, wr_conflict=1 for exactly one cycle, and a same-cycle bypass read returns 0x22.
- issue_en to x3 → busy_vec[3]=1 and busy_cnt=1 next cycle. A write to x3 clears both after the edge, while rd_busy for x3 drops in the write cycle.
- Same cycle: issue x9 and write x9 → busy_vec[9]=1 after the edge. Then flush with issue x10 → busy_vec=0 and busy_cnt=0.
- Write x12=0xFF, then assert reset asynchronously between edges → x12 reads 0 and all outputs return to their reset values before the next clk edge.
